pulse_to_hsk: RTL and testbench

PULSE_TO_HSK -- requirements
Module: pulse_to_hsk

---
 rtl/pulse_to_hsk.sv | 100 ++++++++++
 tb/tb_pulse_to_hsk.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_to_hsk.sv
// -----------------------------------------------------------------------------
// pulse_to_hsk
//
// Converts single-clock-domain event pulses into a valid/ready handshake.
// Every rising edge of pulse_i is one event, however many cycles the pulse
// stays high. Events are held in a saturating counter and handed to the
// consumer one per handshake. Events that arrive while the counter is full
// and nothing drains in the same cycle are dropped. A drop raises a sticky
// overflow flag.
//
// Parameters
//   CNT_W      width of the pending-event counter (1..8)
//
// Ports
//   aclk       clock, rising edge
//   arstn      asynchronous active-low reset
//   pulse_i    event pulse, already synchronous to aclk
//   tvalid_o   at least one event is available (registered)
//   tready_i   consumer accepts one event when tvalid_o is high
//   pending_o  number of buffered, not yet accepted events (registered)
//   overflow_o sticky: at least one event was dropped (registered)
//   clr_ovf_i  synchronous clear of overflow_o; a new drop on the same edge wins
// -----------------------------------------------------------------------------
module pulse_to_hsk #(
    parameter int CNT_W = 4
) (
    input  logic             aclk,
    input  logic             arstn,
    input  logic             pulse_i,
    output logic             tvalid_o,
    input  logic             tready_i,
    output logic [CNT_W-1:0] pending_o,
    output logic             overflow_o,
    input  logic             clr_ovf_i
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             prev_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             tvalid_reg;
    logic             ovf_reg;

    logic             event_det;
    logic             pop;
    logic             drop;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_next;

    // prev_reg resets to 1, so a pulse that is already high when reset is
    // released is not treated as an event.
    assign event_det = pulse_i & ~prev_reg;
    assign pop       = tvalid_reg & tready_i;

    // A simultaneous event and pop cancel out. This holds even when the
    // counter is full, so that case is never a drop.
    assign drop = event_det & ~pop & (cnt_reg == CNT_MAX);

    always_comb begin
        cnt_next = cnt_reg;
        if (event_det && !pop && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + 1'b1;
        end else if (pop && !event_det) begin
            // pop implies tvalid_reg, and tvalid_reg implies cnt_reg != 0,
            // so this cannot wrap below zero.
            cnt_next = cnt_reg - 1'b1;
        end
    end

    always_comb begin
        ovf_next = ovf_reg;
        if (drop) begin
            ovf_next = 1'b1;
        end else if (clr_ovf_i) begin
            ovf_next = 1'b0;
        end
    end

    // tvalid is derived from the next counter value. It is therefore
    // registered, yet always equal to (cnt_reg != 0). As a result it cannot
    // drop while events remain.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            prev_reg   <= 1'b1;
            cnt_reg    <= '0;
            tvalid_reg <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            prev_reg   <= pulse_i;
            cnt_reg    <= cnt_next;
            tvalid_reg <= (cnt_next != '0);
            ovf_reg    <= ovf_next;
        end
    end

    assign tvalid_o   = tvalid_reg;
    assign pending_o  = cnt_reg;
    assign overflow_o = ovf_reg;

endmodule

// File: tb/tb_pulse_to_hsk.sv
// -----------------------------------------------------------------------------
// tb_pulse_to_hsk
//
// Directed and random bench for pulse_to_hsk with CNT_W = 4.
// Inputs change 1 ns after each rising edge. Outputs are checked at the same
// point, so each check sees the result of the edge that just happened.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pulse_to_hsk;

    logic       aclk;
    logic       arstn;
    logic       pulse_i;
    logic       tvalid_o;
    logic       tready_i;
    logic [3:0] pending_o;
    logic       overflow_o;
    logic       clr_ovf_i;

    int n_checks = 0;
    int n_fail   = 0;

    pulse_to_hsk #(.CNT_W(4)) dut (
        .aclk       (aclk),
        .arstn      (arstn),
        .pulse_i    (pulse_i),
        .tvalid_o   (tvalid_o),
        .tready_i   (tready_i),
        .pending_o  (pending_o),
        .overflow_o (overflow_o),
        .clr_ovf_i  (clr_ovf_i)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    // Drives one pulse, 1 cycle high then 1 cycle low. The event is sampled
    // at the first edge.
    task automatic pulse_once;
        pulse_i = 1'b1;
        tick();
        pulse_i = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        arstn = 1'b0;
        pulse_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (tvalid_o !== 1'b0 || pending_o !== 4'd0 || overflow_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d: got v=%b p=%0d o=%b, want v=0 p=0 o=0",
                         i, tvalid_o, pending_o, overflow_o);
            end
        end
        arstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (tvalid_o !== 1'b0 || pending_o !== 4'd0 || overflow_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release_high cyc=%0d: got v=%b p=%0d o=%b, want v=0 p=0 o=0",
                         i, tvalid_o, pending_o, overflow_o);
            end
        end
        pulse_i = 1'b0;
        tick();
    endtask

    task automatic test_single;
        pulse_i = 1'b1;
        tick();
        n_checks++;
        if (pending_o !== 4'd1 || tvalid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL single_edge: got p=%0d v=%b, want p=1 v=1", pending_o, tvalid_o);
        end
        tick();  // second high cycle must not add an event
        pulse_i = 1'b0;
        n_checks++;
        if (pending_o !== 4'd1) begin
            n_fail++;
            $display("FAIL single_wide: got p=%0d, want 1", pending_o);
        end
        tick();
        tready_i = 1'b1;
        tick();
        tready_i = 1'b0;
        n_checks++;
        if (pending_o !== 4'd0 || tvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pop: got p=%0d v=%b, want p=0 v=0", pending_o, tvalid_o);
        end
    endtask

    task automatic test_fill_overflow;
        for (int i = 1; i <= 15; i++) begin
            pulse_once();
            n_checks++;
            if (pending_o !== 4'(i) || overflow_o !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_%0d: got p=%0d o=%b, want p=%0d o=0", i, pending_o, overflow_o, i);
            end
        end
        // Event and pop together at full: no change, no overflow.
        pulse_i  = 1'b1;
        tready_i = 1'b1;
        tick();
        pulse_i  = 1'b0;
        tready_i = 1'b0;
        n_checks++;
        if (pending_o !== 4'd15 || overflow_o !== 1'b0 || tvalid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL simultaneous_full: got p=%0d o=%b v=%b, want p=15 o=0 v=1",
                     pending_o, overflow_o, tvalid_o);
        end
        tick();
        // 16th pulse is dropped.
        pulse_once();
        n_checks++;
        if (pending_o !== 4'd15 || overflow_o !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_16th: got p=%0d o=%b, want p=15 o=1", pending_o, overflow_o);
        end
    endtask

    task automatic test_clear_overflow;
        clr_ovf_i = 1'b1;
        tick();
        clr_ovf_i = 1'b0;
        n_checks++;
        if (overflow_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got o=%b, want 0", overflow_o);
        end
        // A clear and a new drop on the same edge: the set wins.
        pulse_i   = 1'b1;
        clr_ovf_i = 1'b1;
        tick();
        pulse_i   = 1'b0;
        clr_ovf_i = 1'b0;
        n_checks++;
        if (overflow_o !== 1'b1 || pending_o !== 4'd15) begin
            n_fail++;
            $display("FAIL ovf_set_wins: got o=%b p=%0d, want o=1 p=15", overflow_o, pending_o);
        end
        tick();
        n_checks++;
        if (overflow_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got o=%b, want 1", overflow_o);
        end
    endtask

    task automatic test_drain;
        tready_i = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            n_checks++;
            if (pending_o !== 4'(15 - i) || tvalid_o !== (i != 15)) begin
                n_fail++;
                $display("FAIL drain_%0d: got p=%0d v=%b, want p=%0d v=%b",
                         i, pending_o, tvalid_o, 15 - i, (i != 15));
            end
        end
        // tready with nothing pending must not wrap the counter.
        tick();
        tick();
        tready_i = 1'b0;
        n_checks++;
        if (pending_o !== 4'd0 || tvalid_o !== 1'b0 || overflow_o !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_no_wrap: got p=%0d v=%b o=%b, want p=0 v=0 o=1",
                     pending_o, tvalid_o, overflow_o);
        end
        clr_ovf_i = 1'b1;
        tick();
        clr_ovf_i = 1'b0;
    endtask

    task automatic test_async_reset;
        pulse_once();
        pulse_once();
        pulse_once();
        n_checks++;
        if (pending_o !== 4'd3) begin
            n_fail++;
            $display("FAIL async_pre: got p=%0d, want 3", pending_o);
        end
        #2 arstn = 1'b0;  // well away from any clock edge
        #1;
        n_checks++;
        if (pending_o !== 4'd0 || tvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got p=%0d v=%b, want p=0 v=0", pending_o, tvalid_o);
        end
        tick();
        arstn = 1'b1;
        // pulse_i is already high at reset release: no event.
        pulse_i = 1'b1;
        tick();
        n_checks++;
        if (pending_o !== 4'd0) begin
            n_fail++;
            $display("FAIL async_no_event: got p=%0d, want 0", pending_o);
        end
        pulse_i = 1'b0;
        tick();
    endtask

    task automatic test_random;
        int m_cnt = 0;
        bit m_ovf = 0;
        bit m_prev = 1;
        int edges = 0, drops = 0, dut_pops = 0;
        int left = 3;
        int rdy_pct;
        bit ev, pp;
        // Start from reset so the model's initial state is known.
        arstn = 1'b0;
        pulse_i = 1'b0;
        tready_i = 1'b0;
        clr_ovf_i = 1'b0;
        tick();
        arstn = 1'b1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            left--;
            if (left == 0) begin
                pulse_i = ~pulse_i;
                left = int'($urandom_range(1, pulse_i ? 4 : 6));
            end
            rdy_pct   = ((cyc / 1000) % 2 == 1) ? 70 : 15;
            tready_i  = ($urandom_range(0, 99) < rdy_pct);
            clr_ovf_i = ($urandom_range(0, 63) == 0);

            ev = pulse_i && !m_prev;
            pp = (m_cnt != 0) && tready_i;
            if (tvalid_o && tready_i) dut_pops++;
            if (ev) edges++;
            if (ev && !pp) begin
                if (m_cnt == 15) begin
                    drops++;
                    m_ovf = 1'b1;
                end else begin
                    m_cnt++;
                    if (clr_ovf_i) m_ovf = 1'b0;
                end
            end else begin
                if (pp && !ev) m_cnt--;
                if (clr_ovf_i) m_ovf = 1'b0;
            end
            m_prev = pulse_i;

            tick();
            n_checks++;
            if (pending_o !== 4'(m_cnt) || tvalid_o !== (m_cnt != 0) || overflow_o !== m_ovf) begin
                n_fail++;
                $display("FAIL random cyc=%0d: got p=%0d v=%b o=%b, want p=%0d v=%b o=%b",
                         cyc, pending_o, tvalid_o, overflow_o, m_cnt, (m_cnt != 0), m_ovf);
            end
        end
        // Drain whatever is left and compare the totals.
        pulse_i = 1'b0;
        clr_ovf_i = 1'b0;
        tready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (tvalid_o) dut_pops++;
            tick();
        end
        tready_i = 1'b0;
        n_checks++;
        if (dut_pops != edges - drops || pending_o !== 4'd0) begin
            n_fail++;
            $display("FAIL random_totals: got pops=%0d p=%0d, want pops=%0d (edges=%0d drops=%0d) p=0",
                     dut_pops, pending_o, edges - drops, edges, drops);
        end
        $display("random: edges=%0d drops=%0d pops=%0d", edges, drops, dut_pops);
    endtask

    initial begin
        arstn     = 1'b0;
        pulse_i   = 1'b0;
        tready_i  = 1'b0;
        clr_ovf_i = 1'b0;
        test_reset();
        test_single();
        test_fill_overflow();
        test_clear_overflow();
        test_drain();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
